// File: rtl/alu_issue_unit.sv
// ALU issue stage: decodes RV32I ALU commands into a 4-bit ALU control code,
// drives the external combinational ALU and registers its result with backpressure.
module alu_issue_unit #(
   parameter int TAG_W   = 4,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [6:0]         in_opcode,
   input  logic [2:0]         in_funct3,
   input  logic [6:0]         in_funct7,
   input  logic [31:0]        in_a,
   input  logic [31:0]        in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic [31:0]        alu_a,
   output logic [31:0]        alu_b,
   output logic [3:0]         alu_con,
   input  logic [31:0]        alu_res,
   input  logic               alu_zero,
   input  logic               alu_carry,
   input  logic               alu_overflow,
   input  logic               alu_neg,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_res,
   output logic               out_zero,
   output logic               out_carry,
   output logic               out_overflow,
   output logic               out_neg,
   output logic               out_illegal,
   output logic [TAG_W-1:0]   out_tag,
   input  logic               flags_clr,
   output logic               sticky_ovf,
   output logic [COUNT_W-1:0] op_count
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   // funct3 to ALU code; alt selects SUB/SRA
   function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
      logic [3:0] con;
      case (f3)
         3'b000:  con = alt ? 4'b0001 : 4'b0000;
         3'b001:  con = 4'b1010;
         3'b010:  con = 4'b0101;
         3'b011:  con = 4'b0110;
         3'b100:  con = 4'b0100;
         3'b101:  con = alt ? 4'b1011 : 4'b1100;
         3'b110:  con = 4'b0011;
         3'b111:  con = 4'b0010;
         default: con = 4'b0000;
      endcase
      return con;
   endfunction

   // Returns {illegal, alu_con}; illegal commands always carry code 0000
   function automatic logic [4:0] decode_cmd(input logic [6:0] opc, input logic [2:0] f3,
                                             input logic [6:0] f7);
      logic       ill;
      logic [3:0] con;
      logic       alt;
      ill = 1'b0;
      con = 4'b0000;
      alt = (f7 == F7_ALT);
      case (opc)
         OPC_OP: begin
            if ((f7 != F7_BASE) && !alt) begin
               ill = 1'b1;
            end else if (alt && (f3 != 3'b000) && (f3 != 3'b101)) begin
               ill = 1'b1;
            end else begin
               con = alu_code(f3, alt);
            end
         end
         OPC_OPIMM: begin
            case (f3)
               3'b000: con = 4'b0000;
               3'b001: begin
                  if (f7 == F7_BASE) begin
                     con = 4'b1010;
                  end else begin
                     ill = 1'b1;
                  end
               end
               3'b101: begin
                  if ((f7 == F7_BASE) || alt) begin
                     con = alu_code(f3, alt);
                  end else begin
                     ill = 1'b1;
                  end
               end
               default: con = alu_code(f3, 1'b0);
            endcase
         end
         OPC_LUI:   con = 4'b1001;
         OPC_AUIPC: con = 4'b1000;
         default:   ill = 1'b1;
      endcase
      return {ill, ill ? 4'b0000 : con};
   endfunction

   logic               d_valid_r;
   logic [31:0]        d_a_r;
   logic [31:0]        d_b_r;
   logic [3:0]         d_con_r;
   logic               d_ill_r;
   logic [TAG_W-1:0]   d_tag_r;
   logic               out_valid_r;
   logic [31:0]        out_res_r;
   logic               out_zero_r;
   logic               out_carry_r;
   logic               out_overflow_r;
   logic               out_neg_r;
   logic               out_ill_r;
   logic [TAG_W-1:0]   out_tag_r;
   logic               sticky_r;
   logic [COUNT_W-1:0] count_r;
   logic               e_ready_s;
   logic               in_ready_s;
   logic               xfer_s;
   logic [4:0]         dec_s;

   assign e_ready_s  = !out_valid_r || out_ready;
   assign in_ready_s = !d_valid_r || e_ready_s;
   assign xfer_s     = out_valid_r && out_ready;
   assign dec_s      = decode_cmd(in_opcode, in_funct3, in_funct7);

   // D stage: holds the decoded command and operands presented to the ALU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_valid_r <= 1'b0;
         d_a_r     <= 32'd0;
         d_b_r     <= 32'd0;
         d_con_r   <= 4'b0000;
         d_ill_r   <= 1'b0;
         d_tag_r   <= {TAG_W{1'b0}};
      end else if (in_ready_s) begin
         d_valid_r <= in_valid;
         if (in_valid) begin
            d_a_r   <= in_a;
            d_b_r   <= in_b;
            d_con_r <= dec_s[3:0];
            d_ill_r <= dec_s[4];
            d_tag_r <= in_tag;
         end
      end
   end

   // Output stage: captures the ALU result, masked to zero for illegal commands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r    <= 1'b0;
         out_res_r      <= 32'd0;
         out_zero_r     <= 1'b0;
         out_carry_r    <= 1'b0;
         out_overflow_r <= 1'b0;
         out_neg_r      <= 1'b0;
         out_ill_r      <= 1'b0;
         out_tag_r      <= {TAG_W{1'b0}};
      end else if (e_ready_s) begin
         out_valid_r <= d_valid_r;
         if (d_valid_r) begin
            out_res_r      <= d_ill_r ? 32'd0 : alu_res;
            out_zero_r     <= alu_zero     & ~d_ill_r;
            out_carry_r    <= alu_carry    & ~d_ill_r;
            out_overflow_r <= alu_overflow & ~d_ill_r;
            out_neg_r      <= alu_neg      & ~d_ill_r;
            out_ill_r      <= d_ill_r;
            out_tag_r      <= d_tag_r;
         end
      end
   end

   // Sticky overflow (a set beats a simultaneous clear) and saturating transfer count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_r <= 1'b0;
         count_r  <= {COUNT_W{1'b0}};
      end else begin
         if (xfer_s && out_overflow_r) begin
            sticky_r <= 1'b1;
         end else if (flags_clr) begin
            sticky_r <= 1'b0;
         end
         if (xfer_s && (count_r != {COUNT_W{1'b1}})) begin
            count_r <= count_r + COUNT_W'(1);
         end
      end
   end

   assign in_ready     = in_ready_s;
   assign alu_a        = d_a_r;
   assign alu_b        = d_b_r;
   assign alu_con      = d_con_r;
   assign out_valid    = out_valid_r;
   assign out_res      = out_res_r;
   assign out_zero     = out_zero_r;
   assign out_carry    = out_carry_r;
   assign out_overflow = out_overflow_r;
   assign out_neg      = out_neg_r;
   assign out_illegal  = out_ill_r;
   assign out_tag      = out_tag_r;
   assign sticky_ovf   = sticky_r;
   assign op_count     = count_r;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Randomized and directed bench for alu_issue_unit: an ALU model drives alu_*,
// and a scoreboard predicts every output transfer from the command semantics.
module tb_alu_issue_unit;
   localparam int TAG_W   = 4;
   localparam int COUNT_W = 16;

   localparam int OP_ILL = 0, OP_ADD = 1, OP_SUB = 2, OP_SLL = 3, OP_SLT = 4, OP_SLTU = 5;
   localparam int OP_XOR = 6, OP_SRL = 7, OP_SRA = 8, OP_OR = 9, OP_AND = 10;
   localparam int OP_LUI = 11, OP_AUIPC = 12, OP_JUNK = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n, in_valid, in_ready, out_valid, out_ready, flags_clr, sticky_ovf;
   logic [6:0]         in_opcode, in_funct7;
   logic [2:0]         in_funct3;
   logic [31:0]        in_a, in_b, alu_a, alu_b, alu_res, out_res;
   logic [TAG_W-1:0]   in_tag, out_tag;
   logic [3:0]         alu_con;
   logic               alu_zero, alu_carry, alu_overflow, alu_neg;
   logic               out_zero, out_carry, out_overflow, out_neg, out_illegal;
   logic [COUNT_W-1:0] op_count;
   logic [35:0]        alu_vec;

   alu_issue_unit #(.TAG_W(TAG_W), .COUNT_W(COUNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_con(alu_con), .alu_res(alu_res),
      .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_neg(alu_neg),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .out_zero(out_zero), .out_carry(out_carry), .out_overflow(out_overflow), .out_neg(out_neg),
      .out_illegal(out_illegal), .out_tag(out_tag),
      .flags_clr(flags_clr), .sticky_ovf(sticky_ovf), .op_count(op_count)
   );

   typedef struct packed {
      logic [31:0]      res;
      logic             z;
      logic             c;
      logic             v;
      logic             n;
      logic             ill;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t               q[$];
   int                 checks = 0;
   int                 errors = 0;
   logic               sticky_m = 1'b0;
   int                 cnt_m = 0;
   logic               last_acc = 1'b0;
   logic               saw_stall = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Semantic ALU operation: returns {res, zero, carry, overflow, neg}
   function automatic logic [35:0] exec_op(input int op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      r = 32'd0; c = 1'b0; v = 1'b0;
      case (op)
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         OP_SUB: begin
            r = a - b; c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         OP_SLL:   r = a << b[4:0];
         OP_SRL:   r = a >> b[4:0];
         OP_SRA:   r = $signed(a) >>> b[4:0];
         OP_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
         OP_XOR:   r = a ^ b;
         OP_OR:    r = a | b;
         OP_AND:   r = a & b;
         OP_LUI:   r = b;
         OP_AUIPC: r = a + b;
         default: begin r = a ^ 32'hdeadbeef; c = 1'b1; v = 1'b1; end
      endcase
      return {r, (r == 32'd0), c, v, r[31]};
   endfunction

   // The ALU's documented control-code table
   function automatic int con_to_op(input logic [3:0] con);
      case (con)
         4'b0000: return OP_ADD;   4'b0001: return OP_SUB;
         4'b1010: return OP_SLL;   4'b0101: return OP_SLT;
         4'b0110: return OP_SLTU;  4'b0100: return OP_XOR;
         4'b1100: return OP_SRL;   4'b1011: return OP_SRA;
         4'b0011: return OP_OR;    4'b0010: return OP_AND;
         4'b1001: return OP_LUI;   4'b1000: return OP_AUIPC;
         default: return OP_JUNK;
      endcase
   endfunction

   // Combinational ALU model driving the DUT's alu_* inputs
   always_comb begin
      alu_vec = exec_op(con_to_op(alu_con), alu_a, alu_b);
   end
   assign {alu_res, alu_zero, alu_carry, alu_overflow, alu_neg} = alu_vec;

   // Instruction meaning from RV32I encoding rules
   function automatic int ref_decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
      int ops[8];
      ops = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
      if (opc == 7'b0110111) return OP_LUI;
      if (opc == 7'b0010111) return OP_AUIPC;
      if (opc == 7'b0110011) begin
         if (f7 == 7'h00) return ops[f3];
         if (f7 == 7'h20 && f3 == 3'd0) return OP_SUB;
         if (f7 == 7'h20 && f3 == 3'd5) return OP_SRA;
         return OP_ILL;
      end
      if (opc == 7'b0010011) begin
         if (f3 == 3'd1 || f3 == 3'd5) begin
            if (f7 == 7'h00) return ops[f3];
            if (f7 == 7'h20 && f3 == 3'd5) return OP_SRA;
            return OP_ILL;
         end
         return ops[f3];
      end
      return OP_ILL;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      int   op;
      op = ref_decode(in_opcode, in_funct3, in_funct7);
      e.tag = in_tag;
      if (op == OP_ILL) begin
         {e.res, e.z, e.c, e.v, e.n} = 36'd0;
         e.ill = 1'b1;
      end else begin
         {e.res, e.z, e.c, e.v, e.n} = exec_op(op, in_a, in_b);
         e.ill = 1'b0;
      end
      return e;
   endfunction

   // One clock: compare against the model just before the edge, then advance
   task automatic step();
      exp_t e;
      logic xfer, acc;
      #1;
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      if (q.size() == 0) check("idle_out_valid", out_valid, 0);
      if (q.size() == 2) check("full_out_valid", out_valid, 1);
      check("sticky_ovf", sticky_ovf, sticky_m);
      check("op_count", op_count, cnt_m);
      if (!in_ready) saw_stall = 1'b1;
      xfer = out_valid && out_ready;
      acc  = in_valid && in_ready;
      last_acc = acc;
      if (xfer && q.size() > 0) begin
         e = q.pop_front();
         check("out_res", out_res, e.res);
         check("out_flags", {out_zero, out_carry, out_overflow, out_neg}, {e.z, e.c, e.v, e.n});
         check("out_illegal", out_illegal, e.ill);
         check("out_tag", out_tag, e.tag);
         if (cnt_m < (1 << COUNT_W) - 1) cnt_m++;
      end
      if (xfer && out_overflow) sticky_m = 1'b1;
      else if (flags_clr) sticky_m = 1'b0;
      if (acc) q.push_back(predict());
      @(negedge clk);
   endtask

   task automatic set_cmd(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
      in_opcode = opc; in_funct3 = f3; in_funct7 = f7; in_a = a; in_b = b; in_tag = tag;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) step();
      check("drain_remaining", q.size(), 0);
      step();
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h7fffffff;
         1:       return 32'h80000000;
         2:       return 32'hffffffff;
         3:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_cmd();
      logic [6:0] opc, f7;
      case ($urandom_range(0, 9))
         0, 1, 2, 3: opc = 7'b0110011;
         4, 5, 6:    opc = 7'b0010011;
         7:          opc = 7'b0110111;
         8:          opc = 7'b0010111;
         default:    opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0, 1:    f7 = 7'h00;
         2:       f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      set_cmd(opc, 3'($urandom), f7, rand_operand(), rand_operand(), TAG_W'($urandom));
   endtask

   int cnt0;
   int sent;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
      set_cmd(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
      #6;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_res", out_res, 0);
      check("rst_alu_con", alu_con, 0);
      check("rst_alu_ab", {alu_a, alu_b} == 64'd0, 1);
      check("rst_sticky", sticky_ovf, 0);
      check("rst_op_count", op_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // ADD overflow with latency and sticky checks
      set_cmd(7'b0110011, 3'd0, 7'h00, 32'h7fffffff, 32'd1, 4'd5);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #1 check("lat_not_yet", out_valid, 0);
      step();
      #1 check("lat_valid", out_valid, 1);
      check("add_res", out_res, 32'h80000000);
      check("add_ovf_neg_carry", {out_overflow, out_neg, out_carry}, 3'b110);
      step();
      #1 check("add_sticky", sticky_ovf, 1);
      step();

      // SUB equal operands, then OP-IMM SRA
      set_cmd(7'b0110011, 3'd0, 7'h20, 32'd5, 32'd5, 4'd6);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #1 check("sub_alu_con", alu_con, 4'b0001);
      step();
      #1 check("sub_res", out_res, 0);
      check("sub_zero", out_zero, 1);
      step();
      set_cmd(7'b0010011, 3'd5, 7'h20, 32'h80000000, 32'd4, 4'd7);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      #1 check("srai_res", out_res, 32'hf8000000);
      drain();

      // Two illegal commands back to back
      cnt0 = int'(op_count);
      set_cmd(7'b0000011, 3'd0, 7'h00, 32'd9, 32'd9, 4'd8);
      in_valid = 1'b1;
      step();
      set_cmd(7'b0110011, 3'd0, 7'h01, 32'd9, 32'd9, 4'd9);
      step();
      drain();
      check("illegal_count", op_count, 32'(cnt0 + 2));

      // Backpressure: four tagged ADDs with a 3-cycle out_ready gap
      sent = 0;
      saw_stall = 1'b0;
      for (int cyc = 0; cyc < 40 && (sent < 4 || q.size() > 0); cyc++) begin
         out_ready = !(cyc >= 2 && cyc < 5);
         in_valid = (sent < 4);
         set_cmd(7'b0110011, 3'd0, 7'h00, 32'(1000 * (sent + 1)), 32'(sent + 1), TAG_W'(sent + 1));
         step();
         if (last_acc) sent++;
      end
      check("bp_sent", sent, 4);
      check("bp_stall_seen", saw_stall, 1);
      drain();

      // Clear coinciding with an overflowing transfer, then clear alone
      flags_clr = 1'b1;
      step();
      flags_clr = 1'b0;
      set_cmd(7'b0110011, 3'd0, 7'h00, 32'h80000000, 32'h80000000, 4'd3);
      in_valid = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      step();
      flags_clr = 1'b1;
      out_ready = 1'b1;
      step();
      flags_clr = 1'b0;
      #1 check("clr_vs_set", sticky_ovf, 1);
      step();
      flags_clr = 1'b1;
      step();
      flags_clr = 1'b0;
      #1 check("clr_alone", sticky_ovf, 0);
      step();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flags_clr = ($urandom_range(0, 9) == 0);
         rand_cmd();
         step();
      end
      flags_clr = 1'b0;
      drain();

      // Asynchronous reset with two commands in flight
      set_cmd(7'b0110011, 3'd0, 7'h00, 32'd1, 32'd2, 4'd1);
      in_valid = 1'b1;
      step();
      set_cmd(7'b0110011, 3'd0, 7'h00, 32'd3, 32'd4, 4'd2);
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("arst_out_valid", out_valid, 0);
      check("arst_op_count", op_count, 0);
      q.delete();
      sticky_m = 1'b0;
      cnt_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      set_cmd(7'b0110011, 3'd0, 7'h00, 32'd10, 32'd20, 4'd11);
      in_valid = 1'b1;
      step();
      drain();
      check("post_rst_count", op_count, 1);
      check("post_rst_res", out_res, 32'd30);
      check("post_rst_tag", out_tag, 4'd11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
